// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D cache fill logic, the arbiter and main memory.
//   slave  : arbiter side. It takes requests and memory returns, and drives the
//            fill results and the memory strobes.
//   master : environment side (caches plus memory). It drives requests and memory
//            returns, and observes fills and memory strobes.
interface mem_arbiter_if;
    // Cache-side requests
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic [15:0] d_addr;
    logic        d_wr;
    logic [15:0] d_wdata;
    // Fill returns and completion pulses
    logic        i_fill_valid;
    logic        d_fill_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_idx;
    logic        i_done;
    logic        d_done;
    logic        d_wr_ack;
    // Memory port
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wr, d_wdata, mem_rdata, mem_valid,
        output i_fill_valid, d_fill_valid, fill_data, fill_idx, i_done, d_done, d_wr_ack,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, d_wr, d_wdata, mem_rdata, mem_valid,
        input  i_fill_valid, d_fill_valid, fill_data, fill_idx, i_done, d_done, d_wr_ack,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one pipelined main-memory port between an I-cache and a D-cache.
// A D-side single-word write-through wins over a D block fill, which wins over an
// I block fill. A fill issues BLK_WORDS reads back to back. Returned words are
// passed straight through to the owning cache, tagged with their index in the block.
//   clk, rst_n : clock and asynchronous active-low reset.
//   bus        : mem_arbiter_if.slave. It carries the requests, fill results,
//                completion pulses and the memory port.
module mem_arbiter #(
    parameter int unsigned MEM_LAT   = 4,
    parameter int unsigned BLK_WORDS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    // One extra bit so a counter can hold the value BLK_WORDS itself.
    localparam int unsigned CntW = IdxW + 1;
    localparam logic [CntW-1:0] BlkWords = CntW'(BLK_WORDS);

    // Returns are counted against issues, so the latency value only needs to be sane.
    if (MEM_LAT < 1) begin : g_lat_check
        $error("MEM_LAT must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StWrite, StDFill, StIFill} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] iss_q, iss_d;
    logic [CntW-1:0] ret_q, ret_d;
    logic [11:0]     base_q, base_d;

    logic in_fill, ret_ok, last_ret;

    assign in_fill  = (state_q == StDFill) || (state_q == StIFill);
    // A return counts only if a matching read is still outstanding.
    assign ret_ok   = in_fill && bus.mem_valid && (ret_q < iss_q);
    assign last_ret = ret_ok && (ret_q == BlkWords - CntW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            iss_q   <= '0;
            ret_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            ret_q   <= ret_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        iss_d            = iss_q;
        ret_d            = ret_q;
        base_d           = base_q;
        bus.i_fill_valid = 1'b0;
        bus.d_fill_valid = 1'b0;
        bus.fill_data    = '0;
        bus.fill_idx     = '0;
        bus.i_done       = 1'b0;
        bus.d_done       = 1'b0;
        bus.d_wr_ack     = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_wr       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.d_wr) begin
                    state_d = StWrite;
                end else if (bus.d_req) begin
                    state_d = StDFill;
                    base_d  = bus.d_addr[15:4];
                end else if (bus.i_req) begin
                    state_d = StIFill;
                    base_d  = bus.i_addr[15:4];
                end
            end

            StWrite: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.d_wr_ack  = 1'b1;
                state_d       = StIdle;
            end

            StDFill, StIFill: begin
                if (iss_q < BlkWords) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = {base_q, 4'b0000} + 16'({iss_q, 1'b0});
                    iss_d        = iss_q + CntW'(1);
                end
                if (ret_ok) begin
                    bus.fill_data = bus.mem_rdata;
                    bus.fill_idx  = 3'(ret_q);
                    ret_d         = ret_q + CntW'(1);
                    if (state_q == StDFill) begin
                        bus.d_fill_valid = 1'b1;
                    end else begin
                        bus.i_fill_valid = 1'b1;
                    end
                end
                if (last_ret) begin
                    if (state_q == StDFill) begin
                        bus.d_done = 1'b1;
                    end else begin
                        bus.i_done = 1'b1;
                    end
                    state_d = StIdle;
                    iss_d   = '0;
                    ret_d   = '0;
                end
            end

            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int Lat = 4;

    typedef struct packed {
        logic        side;  // 1 = I-side, 0 = D-side
        logic [2:0]  idx;
        logic [15:0] data;
        logic        last;
    } fill_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_total;
    int   n_bad;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MEM_LAT   (Lat),
        .BLK_WORDS (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: pipelined reads, data = address ^ 0x5A5A, reset with the DUT.
    logic [Lat-1:0] pv;
    logic [15:0]    pd [Lat];
    logic           spur_v;
    logic [15:0]    spur_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int k = 0; k < Lat; k++) pd[k] <= '0;
        end else begin
            pv    <= {pv[Lat-2:0], bus.mem_en & ~bus.mem_wr};
            pd[0] <= bus.mem_addr ^ 16'h5A5A;
            for (int k = 1; k < Lat; k++) pd[k] <= pd[k-1];
        end
    end

    assign bus.mem_valid = pv[Lat-1] | spur_v;
    assign bus.mem_rdata = spur_v ? spur_d : pd[Lat-1];

    // Scoreboard queues
    logic [15:0] exp_rd [$];
    fill_t       exp_fill [$];
    wr_t         exp_wr [$];

    int i_done_n, d_done_n, wr_ack_n;
    int i_done_cyc, d_done_cyc, wr_ack_cyc, first_rd_cyc;
    logic prev_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard.
    always @(negedge clk) begin
        fill_t f;
        wr_t   w;
        logic  rd;
        rd = bus.mem_en & ~bus.mem_wr;
        if (rd) begin
            if (!prev_rd) first_rd_cyc = cyc;
            if (exp_rd.size() == 0) begin
                chk("rd_unexp", 64'(bus.mem_en), 64'(0));
            end else begin
                chk("rd_addr", 64'(bus.mem_addr), 64'(exp_rd.pop_front()));
            end
        end
        prev_rd = rd;
        if (bus.mem_en && bus.mem_wr) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexp", 64'(bus.mem_wr), 64'(0));
            end else begin
                w = exp_wr.pop_front();
                chk("wr_addr", 64'(bus.mem_addr), 64'(w.addr));
                chk("wr_data", 64'(bus.mem_wdata), 64'(w.data));
                chk("wr_ack", 64'(bus.d_wr_ack), 64'(1));
            end
        end
        if (bus.d_wr_ack) begin
            wr_ack_n++;
            wr_ack_cyc = cyc;
            if (!(bus.mem_en && bus.mem_wr)) chk("ack_alone", 64'(bus.d_wr_ack), 64'(0));
        end
        if (bus.i_fill_valid || bus.d_fill_valid) begin
            chk("both_fv", 64'(bus.i_fill_valid & bus.d_fill_valid), 64'(0));
            if (exp_fill.size() == 0) begin
                chk("fill_unexp", 64'({bus.i_fill_valid, bus.d_fill_valid}), 64'(0));
            end else begin
                f = exp_fill.pop_front();
                chk("fill_side", 64'(bus.i_fill_valid), 64'(f.side));
                chk("fill_idx", 64'(bus.fill_idx), 64'(f.idx));
                chk("fill_data", 64'(bus.fill_data), 64'(f.data));
                chk("i_done", 64'(bus.i_done), 64'(f.side & f.last));
                chk("d_done", 64'(bus.d_done), 64'(~f.side & f.last));
            end
        end else if (bus.i_done || bus.d_done) begin
            chk("done_alone", 64'({bus.i_done, bus.d_done}), 64'(0));
        end
        if (bus.i_done) begin
            i_done_n++;
            i_done_cyc = cyc;
        end
        if (bus.d_done) begin
            d_done_n++;
            d_done_cyc = cyc;
        end
    end

    task automatic push_fill(input logic side, input logic [15:0] base);
        fill_t f;
        for (int k = 0; k < 8; k++) begin
            exp_rd.push_back(base + 16'(2 * k));
            f.side = side;
            f.idx  = 3'(k);
            f.data = (base + 16'(2 * k)) ^ 16'h5A5A;
            f.last = (k == 7);
            exp_fill.push_back(f);
        end
    endtask

    task automatic wait_done(input logic side, input int prev);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge clk);
            #1;
            got = side ? (i_done_n != prev) : (d_done_n != prev);
        end
        chk(side ? "i_done_timeout" : "d_done_timeout", 64'(got), 64'(1));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.i_fill_valid, bus.d_fill_valid, bus.fill_data, bus.fill_idx,
                    bus.i_done, bus.d_done, bus.d_wr_ack, bus.mem_en, bus.mem_wr,
                    bus.mem_addr, bus.mem_wdata});
    endfunction

    initial begin
        int s, pi, pd_n, pw;
        logic wr_on, dq_on, iq_on;
        n_total = 0; n_bad = 0; cyc = 0;
        i_done_n = 0; d_done_n = 0; wr_ack_n = 0;
        i_done_cyc = -1; d_done_cyc = -1; wr_ack_cyc = -1; first_rd_cyc = -1;
        prev_rd = 1'b0;
        spur_v = 1'b0; spur_d = '0;
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_addr = '0;
        bus.d_wr = 0; bus.d_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outs", all_outs(), 64'(0));
        @(negedge clk); #1 rst_n = 1'b1;
        #1 chk("post_reset_outs", all_outs(), 64'(0));

        // I fill 0x0126: reads 0x0120..0x012E, done in the 12th cycle
        @(negedge clk); #1;
        s = cyc + 1; pi = i_done_n;
        push_fill(1'b1, 16'h0120);
        bus.i_req = 1; bus.i_addr = 16'h0126;
        wait_done(1'b1, pi);
        bus.i_req = 0;
        chk("t1_first_rd", 64'(first_rd_cyc), 64'(s));
        chk("t1_done_cyc", 64'(i_done_cyc), 64'(s + 11));

        // Write + D fill + I fill together: write, then D fill, then I fill
        @(negedge clk); #1;
        s = cyc + 1; pi = i_done_n; pd_n = d_done_n; pw = wr_ack_n;
        exp_wr.push_back('{addr: 16'h4002, data: 16'hBEEF});
        push_fill(1'b0, 16'h4000);
        push_fill(1'b1, 16'h0340);
        bus.d_wr = 1; bus.d_addr = 16'h4002; bus.d_wdata = 16'hBEEF;
        bus.d_req = 1; bus.i_req = 1; bus.i_addr = 16'h0340;
        wr_on = 1; dq_on = 1; iq_on = 1;
        for (int k = 0; k < 80 && (wr_on || dq_on || iq_on); k++) begin
            @(posedge clk); #1;
            if (wr_ack_n != pw) begin bus.d_wr = 0; wr_on = 0; end
            if (d_done_n != pd_n) begin bus.d_req = 0; dq_on = 0; end
            if (i_done_n != pi) begin bus.i_req = 0; iq_on = 0; end
        end
        chk("t2_timeout", 64'({wr_on, dq_on, iq_on}), 64'(0));
        chk("t2_ack_cyc", 64'(wr_ack_cyc), 64'(s));
        chk("t2_d_done_cyc", 64'(d_done_cyc), 64'(s + 13));
        chk("t2_i_done_cyc", 64'(i_done_cyc), 64'(s + 26));

        // Request dropped and address changed mid-fill
        @(negedge clk); #1;
        s = cyc + 1; pi = i_done_n;
        push_fill(1'b1, 16'h0120);
        bus.i_req = 1; bus.i_addr = 16'h0126;
        repeat (3) @(posedge clk);
        #1 bus.i_req = 0; bus.i_addr = 16'hFFF0;
        wait_done(1'b1, pi);
        chk("t3_done_cyc", 64'(i_done_cyc), 64'(s + 11));

        // Reset in cycle 6 of a fill aborts it; D fill afterwards is clean
        @(negedge clk); #1;
        s = cyc + 1; pi = i_done_n;
        push_fill(1'b1, 16'h0120);
        bus.i_req = 1; bus.i_addr = 16'h0126;
        repeat (6) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b0;
        #1 chk("t4_async_outs", all_outs(), 64'(0));
        chk("t4_rd_left", 64'(exp_rd.size()), 64'(2));
        chk("t4_fill_left", 64'(exp_fill.size()), 64'(6));
        exp_rd.delete();
        exp_fill.delete();
        bus.i_req = 0;
        repeat (2) @(posedge clk);
        #1 chk("t4_hold_outs", all_outs(), 64'(0));
        @(negedge clk); #1 rst_n = 1'b1;
        chk("t4_no_done", 64'(i_done_n), 64'(pi));
        @(negedge clk); #1;
        s = cyc + 1; pd_n = d_done_n;
        push_fill(1'b0, 16'h2460);
        bus.d_req = 1; bus.d_addr = 16'h2468;
        wait_done(1'b0, pd_n);
        bus.d_req = 0;
        chk("t4_d_done_cyc", 64'(d_done_cyc), 64'(s + 11));

        // Spurious mem_valid in IDLE and in the first fill cycle is ignored
        @(negedge clk); #1;
        spur_v = 1; spur_d = 16'h1234;
        #1 chk("t5_idle_spur", 64'({bus.i_fill_valid, bus.d_fill_valid, bus.fill_data}), 64'(0));
        @(posedge clk); #1 spur_v = 0;
        @(negedge clk); #1;
        s = cyc + 1; pi = i_done_n;
        push_fill(1'b1, 16'hABC0);
        bus.i_req = 1; bus.i_addr = 16'hABCF;
        @(posedge clk); #1;
        spur_v = 1;
        #1 chk("t5_fill_spur", 64'({bus.i_fill_valid, bus.d_fill_valid, bus.fill_data}), 64'(0));
        @(negedge clk); #1 spur_v = 0;
        wait_done(1'b1, pi);
        bus.i_req = 0;
        chk("t5_done_cyc", 64'(i_done_cyc), 64'(s + 11));

        repeat (6) @(posedge clk);
        #1;
        chk("end_rd_q", 64'(exp_rd.size()), 64'(0));
        chk("end_fill_q", 64'(exp_fill.size()), 64'(0));
        chk("end_wr_q", 64'(exp_wr.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
